seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Parametrised, time-multiplexed seven-segment display driver for DIGITS BCD/hex digits. It is the successor to the single-digit combinational decoder. It decodes each digit to segments a..g, scans the digits one at a time through a one-hot digit enable, and double-buffers the displayed value so a display never shows a torn update. It sits between the datapath (counters, test results) and the board's multiplexed display pins.

## Interface
- DIGITS, 4: number of digits scanned, legal range 1..8.
- CLK_DIV, 50000: clk cycles each digit stays enabled, legal range ≥1.
- ACTIVE_LOW, 0: 1 inverts seg, dp and an at the pins.
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digits_in  input  4*DIGITS  digit k occupies bits [4k+3:4k]; digit 0 is least significant and rightmost.
- dp_in  input  DIGITS  decimal point request per digit.
- load  input  1  capture digits_in/dp_in into the pending buffer.
- blank_lz  input  1  enable leading-zero blanking.
- seg  output  7  segments {a,b,c,d,e,f,g}, with a at bit 6.
- dp  output  1  decimal point of the enabled digit.
- an  output  DIGITS  one-hot digit enable; an[k] drives digit k.
- frame_done  output  1  one-cycle pulse when the scan wraps.

## Operation
- The block holds two buffers: pending (written by load) and active (displayed). Both are 4*DIGITS+DIGITS bits and reset to 0.
- A prescaler counts 0..CLK_DIV-1, with width $clog2(CLK_DIV), minimum 1. `tick` fires when the count is CLK_DIV-1, and the count then returns to 0.
- On tick, the digit index idx advances by 1, wrapping DIGITS-1 → 0. A tick with idx = DIGITS-1 is a wrap tick.
- Load handling:
  - load=1 writes digits_in/dp_in into pending and sets flag pend.
  - On a wrap tick with pend=1, active ← pending and pend is cleared.
  - If load and a wrap tick occur in the same cycle, the newly loaded values go straight into active and pend stays 0 (load bypass).
- Decode (active-high encoding), values 0..9:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
- Values 10..15 decode according to Configuration.
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blanked (seg=0000000) if digits k..DIGITS-1 of active are all 0 and k≠0.
  - Digit 0 is never blanked.
  - dp still follows dp_in of the blanked digit.
  - blank_lz is sampled live, not buffered.
- Outputs are registered, with the polarity from ACTIVE_LOW applied at the register output:
  - an = one-hot(idx).
  - seg = decode(active digit idx), or the blank pattern.
  - dp = active dp[idx].
- frame_done = 1 for the single cycle after a wrap tick, aligned with the an update to digit 0.

## Timing
- Reset, asynchronous, all values "off" in the selected polarity:
  - seg=0000000 (1111111 if ACTIVE_LOW), dp=0 (1), an=0 (all 1).
  - frame_done=0, idx=0, prescaler=0, pend=0, both buffers 0.
- After rst_n deasserts, the first tick occurs on cycle CLK_DIV. an becomes one-hot(1) one cycle after that tick.
  - Exception: DIGITS=1 keeps an=1 and wraps on every tick.
- First valid display: an[0] is driven on the first clock edge after reset release. Outputs are registered, so they lag idx by one cycle.
- Steady state:
  - Each an[k] is active for exactly CLK_DIV consecutive cycles.
  - One frame = DIGITS*CLK_DIV cycles.
  - Exactly one an bit is active at a time; there are no overlap cycles.
- Load-to-display latency: a load becomes visible from the start of the next frame, at most DIGITS*CLK_DIV+1 cycles later. Multiple loads within one frame: the last one wins.
- When CLK_DIV=1, tick is asserted every cycle and idx advances every cycle.
- Reset asserted mid-frame: all outputs go to their reset values immediately, and the pending load is discarded.

## Configuration
- SEG_SCAN_HEX_EN defined: values 10..15 display as hex letters:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- SEG_SCAN_HEX_EN not defined: values 10..15 display 1111110 ("0"), matching the legacy decoder's default.

## Test plan
- Reset/scan (DIGITS=4, CLK_DIV=3): hold rst_n=0, then release. Outputs are at reset values while rst_n=0. After release, an walks 0001→0010→0100→1000 every 3 cycles, and frame_done pulses once every 12 cycles.
- Decode sweep: load digits 0..9 into digit 0 one value at a time. seg matches each listed code, e.g. 6→0011111 and 9→1110011.
- Hex macro: load 0xA into digit 0. seg=1110111 with SEG_SCAN_HEX_EN defined, and 1111110 without it.
- Leading-zero blanking: load 0x0050 with blank_lz=1. Digits 3 and 2 show 0000000, digit 1 shows 1011011, digit 0 shows 1111110. Then load 0x0000: only digit 0 is lit.
- Double buffer: load 0x1234 mid-frame. Current-frame digits are unchanged until the wrap; the next frame shows 1234. Load asserted exactly on the wrap tick appears in the immediately following frame.
- Polarity and reset mid-frame (ACTIVE_LOW=1): an is active-low one-hot, and digit 1 shows seg=1001111. Asserting rst_n=0 mid-digit forces seg=1111111 and an=1111 asynchronously.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver with double-buffered digits and leading-zero blanking.
// Define SEG_SCAN_HEX_EN to show values 10..15 as hex letters; otherwise they show "0".
module seg_scan_mux #(
    parameter int DIGITS     = 4,
    parameter int CLK_DIV    = 50000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_mux: DIGITS must be in 1..8");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("seg_scan_mux: CLK_DIV must be at least 1");
        end
    endgenerate

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic                  wrap_q;

    logic [4*DIGITS-1:0]   pend_dig;
    logic [DIGITS-1:0]     pend_dp;
    logic                  pend;
    logic [4*DIGITS-1:0]   act_dig;
    logic [DIGITS-1:0]     act_dp;

    logic [DIGITS-1:0]     lz;
    logic [DIGITS-1:0]     an_next;
    logic [3:0]            cur_val;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [6:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b0011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
`ifdef SEG_SCAN_HEX_EN
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b0011111;
            4'd12:   s = 7'b1001110;
            4'd13:   s = 7'b0111101;
            4'd14:   s = 7'b1001111;
            default: s = 7'b1000111;
`else
            default: s = 7'b1111110;
`endif
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load coinciding with the wrap tick bypasses pending so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dig <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            act_dig  <= '0;
            act_dp   <= '0;
        end else begin
            if (load) begin
                pend_dig <= digits_in;
                pend_dp  <= dp_in;
            end
            if (wrap) begin
                if (load) begin
                    act_dig <= digits_in;
                    act_dp  <= dp_in;
                    pend    <= 1'b0;
                end else if (pend) begin
                    act_dig <= pend_dig;
                    act_dp  <= pend_dp;
                    pend    <= 1'b0;
                end
            end else if (load) begin
                pend <= 1'b1;
            end
        end
    end

    // lz[k]: digit k and everything above it is zero, and k is not the rightmost digit.
    always_comb begin
        logic acc;
        acc = 1'b1;
        lz  = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            acc = acc && (act_dig[4*(DIGITS-1-i) +: 4] == 4'd0);
            lz[DIGITS-1-i] = acc && ((DIGITS - 1 - i) != 0);
        end
    end

    always_comb begin
        cur_val   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_next   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            an_next[i] = (idx == IW'(i));
            if (idx == IW'(i)) begin
                cur_val   = act_dig[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = lz[i];
            end
        end
        seg_next = (blank_lz && cur_blank) ? 7'b0000000 : decode(cur_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= {7{POL}};
            dp         <= POL;
            an         <= {DIGITS{POL}};
            wrap_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next ^ {7{POL}};
            dp         <= cur_dp ^ POL;
            an         <= an_next ^ {DIGITS{POL}};
            wrap_q     <= wrap;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: active-high and active-low instances driven in lockstep,
// display expectations queued at load time and compared frame by frame.
module tb_seg_scan_mux;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 3;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;

    logic [6:0]  seg, seg_l;
    logic        dp, dp_l;
    logic [3:0]  an, an_l;
    logic        frame_done, fd_l;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  p;
    } frame_t;

    frame_t sbq[$];
    frame_t cur = '0;
    int     chk_cnt = 0;
    int     pass_cnt = 0;

    seg_scan_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    seg_scan_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz),
        .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b0011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1110011;
`ifdef SEG_SCAN_HEX_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            default: return 7'b1000111;
`else
            default: return 7'b1111110;
`endif
        endcase
    endfunction

    function automatic logic ref_blank(input logic [15:0] v, input int k, input logic bl);
        if (!bl || k == 0) return 1'b0;
        for (int j = k; j < DIGITS; j++)
            if (v[4*j +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sync_frame();
        for (int i = 0; i < 3 * FRAME && frame_done !== 1'b1; i++) @(negedge clk);
        chk_cnt++;
        if (frame_done !== 1'b1) $display("FAIL sync_frame: frame_done=%b required 1 within budget", frame_done);
        else pass_cnt++;
    endtask

    // Observes one frame from its first cycle, optionally issuing up to two loads at given cycles.
    task automatic test_frame(input int l1, input logic [15:0] v1, input logic [3:0] p1,
                              input int l2, input logic [15:0] v2, input logic [3:0] p2);
        frame_t      e;
        int          d;
        logic [3:0]  dv;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seg;
        logic        exp_dp, exp_fd;
        while (sbq.size() > 0) cur = sbq.pop_front();
        for (int c = 0; c < FRAME; c++) begin
            d       = c / CLK_DIV;
            dv      = cur.v[4*d +: 4];
            exp_an  = 4'(1 << d);
            exp_seg = ref_blank(cur.v, d, blank_lz) ? 7'b0000000 : ref_seg(dv);
            exp_dp  = cur.p[d];
            exp_fd  = (c == 0);
            chk_cnt++;
            if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd})
                $display("FAIL frame c%0d main: an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                         c, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
            else pass_cnt++;
            chk_cnt++;
            if ({an_l, seg_l, dp_l, fd_l} !== {~exp_an, ~exp_seg, ~exp_dp, exp_fd})
                $display("FAIL frame c%0d active_low: an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                         c, an_l, seg_l, dp_l, fd_l, ~exp_an, ~exp_seg, ~exp_dp, exp_fd);
            else pass_cnt++;
            if (c == l1) begin
                digits_in = v1; dp_in = p1; load = 1'b1;
                e.v = v1; e.p = p1; sbq.push_back(e);
            end else if (c == l2) begin
                digits_in = v2; dp_in = p2; load = 1'b1;
                e.v = v2; e.p = p2; sbq.push_back(e);
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({an, seg, dp, frame_done} !== {4'b0000, 7'b0000000, 1'b0, 1'b0})
            $display("FAIL reset main: an=%b seg=%b dp=%b fd=%b required 0000 0000000 0 0", an, seg, dp, frame_done);
        else pass_cnt++;
        chk_cnt++;
        if ({an_l, seg_l, dp_l, fd_l} !== {4'b1111, 7'b1111111, 1'b1, 1'b0})
            $display("FAIL reset active_low: an=%b seg=%b dp=%b fd=%b required 1111 1111111 1 0", an_l, seg_l, dp_l, fd_l);
        else pass_cnt++;
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic       exp_fd;
        rst_n = 1'b1;
        for (int n = 1; n <= 2 * FRAME + 2; n++) begin
            @(negedge clk);
            exp_an = 4'(1 << (((n - 1) / CLK_DIV) % DIGITS));
            exp_fd = (n > 1) && ((n - 1) % FRAME == 0);
            chk_cnt++;
            if ({an, seg, dp, frame_done} !== {exp_an, 7'b1111110, 1'b0, exp_fd})
                $display("FAIL scan n%0d: an=%b seg=%b dp=%b fd=%b required an=%b seg=1111110 dp=0 fd=%b",
                         n, an, seg, dp, frame_done, exp_an, exp_fd);
            else pass_cnt++;
        end
    endtask

    task automatic test_decode();
        sync_frame();
        for (int v = 0; v < 10; v++) test_frame(0, 16'(v), 4'(v & 1), -1, '0, '0);
        test_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_hex();
        for (int v = 10; v < 16; v++) test_frame(0, 16'(v), 4'b0000, -1, '0, '0);
        test_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        @(negedge clk);
        sync_frame();
        test_frame(0, 16'h0050, 4'b0000, -1, '0, '0);
        test_frame(3, 16'h0000, 4'b0100, -1, '0, '0);
        test_frame(0, 16'h0100, 4'b0000, -1, '0, '0);
        test_frame(-1, '0, '0, -1, '0, '0);
        blank_lz = 1'b0;
        @(negedge clk);
        sync_frame();
    endtask

    task automatic test_back_to_back();
        test_frame(5, 16'h1111, 4'b0001, -1, '0, '0);
        test_frame(5, 16'h1234, 4'b0010, -1, '0, '0);
        test_frame(2, 16'h2468, 4'b0000, 7, 16'h1357, 4'b1000);
        test_frame(10, 16'h0987, 4'b0100, -1, '0, '0);
        test_frame(-1, '0, '0, -1, '0, '0);
    endtask

    task automatic test_reset_midframe();
        sync_frame();
        repeat (4) @(negedge clk);
        digits_in = 16'h4321; dp_in = 4'b1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({an, seg, dp, frame_done} !== {4'b0000, 7'b0000000, 1'b0, 1'b0})
            $display("FAIL midframe_reset main: an=%b seg=%b dp=%b fd=%b required 0000 0000000 0 0", an, seg, dp, frame_done);
        else pass_cnt++;
        chk_cnt++;
        if ({an_l, seg_l, dp_l} !== {4'b1111, 7'b1111111, 1'b1})
            $display("FAIL midframe_reset active_low: an=%b seg=%b dp=%b required 1111 1111111 1", an_l, seg_l, dp_l);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        cur = '0;
        sync_frame();
        test_frame(-1, '0, '0, -1, '0, '0);
        test_frame(-1, '0, '0, -1, '0, '0);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_decode();
        test_hex();
        test_blank();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
